// File: rtl/fifo_port_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_port_arbiter
//   Front-end for a DEPTH-entry fifo. Two producers share the fifo write port
//   under round-robin arbitration. One consumer is sequenced onto the read
//   port. A shadow occupancy count (level) is kept in step with the fifo.
//   Traffic stops for good (HALT, err=1) once the fifo reports overflow or
//   underflow. Only rst leaves HALT.
//
// Ports
//   clk, rst                     clock and synchronous active-high reset
//   p0_req/p0_data/p0_gnt        producer 0 request, data, same-cycle grant
//   p1_req/p1_data/p1_gnt        producer 1 request, data, same-cycle grant
//   c_req/c_valid/c_data         consumer request, popped-word valid and data
//   fifo_write/fifo_read         strobes to the fifo
//   fifo_in_data                 write data to the fifo
//   fifo_out_data                read data from the fifo
//   fifo_full/fifo_empty         fifo status flags
//   fifo_overflow/underflow      fifo error flags
//   level                        registered shadow occupancy
//   err                          sticky fault, high while in HALT
// -----------------------------------------------------------------------------
module fifo_port_arbiter #(
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_gnt,
  input  logic              p1_req,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_gnt,
  input  logic              c_req,
  output logic              c_valid,
  output logic [DATA_W-1:0] c_data,
  output logic              fifo_write,
  output logic              fifo_read,
  output logic [DATA_W-1:0] fifo_in_data,
  input  logic [DATA_W-1:0] fifo_out_data,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic              fifo_overflow,
  input  logic              fifo_underflow,
  output logic [CNT_W-1:0]  level,
  output logic              err
);

  localparam logic [CNT_W-1:0] LEVEL_MAX = CNT_W'(DEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   level_q, level_d;
  logic               last_q, last_d;     // index of the most recent grant
  logic               c_valid_q, c_valid_d;

  logic               run;
  logic               wr_ok;
  logic               p0_g, p1_g;
  logic               wr, rd;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    last_d  = last_q;
    p0_g    = 1'b0;
    p1_g    = 1'b0;

    // The ~rst term keeps every strobe low in the cycle reset is asserted.
    run   = (state_q == RUN) && !rst;
    wr_ok = run && !fifo_full && (level_q != LEVEL_MAX);

    if (wr_ok) begin
      unique case ({p1_req, p0_req})
        2'b01:   p0_g = 1'b1;
        2'b10:   p1_g = 1'b1;
        // On a tie, grant whichever producer did not win the last grant.
        2'b11:   if (last_q) p0_g = 1'b1; else p1_g = 1'b1;
        default: ;
      endcase
    end

    wr = p0_g || p1_g;
    rd = run && c_req && !fifo_empty && (level_q != '0);

    // Both strobes in one cycle leave the level unchanged. The gating above
    // already blocks a write at LEVEL_MAX and a read at zero, so it never wraps.
    unique case ({wr, rd})
      2'b10:   level_d = level_q + CNT_W'(1);
      2'b01:   level_d = level_q - CNT_W'(1);
      default: ;
    endcase

    if (p0_g)      last_d = 1'b0;
    else if (p1_g) last_d = 1'b1;

    c_valid_d = rd;

    if (state_q == RUN && (fifo_overflow || fifo_underflow)) state_d = HALT;
  end

  // NOTE: state registers use non-blocking assignments so that every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      level_q   <= '0;
      last_q    <= 1'b1;   // p0 wins the first tie
      c_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      last_q    <= last_d;
      c_valid_q <= c_valid_d;
    end
  end

  assign p0_gnt       = p0_g;
  assign p1_gnt       = p1_g;
  assign fifo_write   = wr;
  assign fifo_read    = rd;
  assign fifo_in_data = p0_g ? p0_data : (p1_g ? p1_data : '0);

  // Registered outputs are also masked by rst, so every output is zero
  // throughout the reset cycle and not only after the first edge.
  assign c_valid = c_valid_q && !rst;
  assign c_data  = c_valid ? fifo_out_data : '0;
  assign level   = rst ? '0 : level_q;
  assign err     = (state_q == HALT) && !rst;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_port_arbiter
//   Directed bench for fifo_port_arbiter. A minimal occupancy model of the
//   fifo drives fifo_full/fifo_empty from the strobes. Overflow and underflow
//   are forced by hand. Inputs change after the falling edge. Outputs are
//   sampled 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       p0_req, p1_req, c_req;
  logic [0:0] p0_data, p1_data, fifo_out_data;
  logic       p0_gnt, p1_gnt, c_valid;
  logic [0:0] c_data, fifo_in_data;
  logic       fifo_write, fifo_read;
  logic       fifo_full, fifo_empty, fifo_overflow, fifo_underflow;
  logic [4:0] level;
  logic       err;

  int n_vec = 0;
  int n_err = 0;
  int tb_cnt = 0;

  always #5 clk = ~clk;

  fifo_port_arbiter #(.DEPTH(16), .CNT_W(5), .DATA_W(1)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_data(p0_data), .p0_gnt(p0_gnt),
    .p1_req(p1_req), .p1_data(p1_data), .p1_gnt(p1_gnt),
    .c_req(c_req), .c_valid(c_valid), .c_data(c_data),
    .fifo_write(fifo_write), .fifo_read(fifo_read),
    .fifo_in_data(fifo_in_data), .fifo_out_data(fifo_out_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow),
    .level(level), .err(err)
  );

  // Occupancy model of the 16-entry fifo, reset by the same rst.
  always @(posedge clk) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= tb_cnt + (fifo_write ? 1 : 0) - (fifo_read ? 1 : 0);
  end
  assign fifo_full  = (tb_cnt == 16);
  assign fifo_empty = (tb_cnt == 0);

  task automatic idle();
    p0_req = 1'b0; p1_req = 1'b0; c_req = 1'b0;
    p0_data = 1'b0; p1_data = 1'b0;
    fifo_overflow = 1'b0; fifo_underflow = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; idle();
    @(negedge clk); rst = 1'b0;
  endtask

  // Drives p0 for n consecutive cycles with alternating data.
  task automatic fill_p0(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); idle(); p0_req = 1'b1; p0_data = 1'(i);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); p0_req = 1'b1; p1_req = 1'b1; c_req = 1'b1; #1;
    n_vec++; if (p0_gnt !== 1'b0)     begin n_err++; $display("FAIL rst_p0_gnt got=%b exp=0", p0_gnt); end
    n_vec++; if (p1_gnt !== 1'b0)     begin n_err++; $display("FAIL rst_p1_gnt got=%b exp=0", p1_gnt); end
    n_vec++; if (fifo_write !== 1'b0) begin n_err++; $display("FAIL rst_write got=%b exp=0", fifo_write); end
    n_vec++; if (fifo_read !== 1'b0)  begin n_err++; $display("FAIL rst_read got=%b exp=0", fifo_read); end
    n_vec++; if (err !== 1'b0)        begin n_err++; $display("FAIL rst_err got=%b exp=0", err); end
    @(negedge clk); rst = 1'b0; idle(); #1;
    n_vec++; if (level !== 5'd0)      begin n_err++; $display("FAIL post_rst_level got=%0d exp=0", level); end
    n_vec++; if (c_valid !== 1'b0)    begin n_err++; $display("FAIL post_rst_c_valid got=%b exp=0", c_valid); end
    n_vec++; if (err !== 1'b0)        begin n_err++; $display("FAIL post_rst_err got=%b exp=0", err); end
  endtask

  task automatic test_p0_stream();
    logic [2:0] pat = 3'b101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); p0_req = 1'b1; p0_data = pat[i]; #1;
      n_vec++; if (p0_gnt !== 1'b1)       begin n_err++; $display("FAIL p0s_gnt[%0d] got=%b exp=1", i, p0_gnt); end
      n_vec++; if (p1_gnt !== 1'b0)       begin n_err++; $display("FAIL p0s_p1gnt[%0d] got=%b exp=0", i, p1_gnt); end
      n_vec++; if (fifo_write !== 1'b1)   begin n_err++; $display("FAIL p0s_write[%0d] got=%b exp=1", i, fifo_write); end
      n_vec++; if (fifo_in_data !== pat[i]) begin n_err++; $display("FAIL p0s_data[%0d] got=%b exp=%b", i, fifo_in_data, pat[i]); end
      n_vec++; if (level !== 5'(i))       begin n_err++; $display("FAIL p0s_level[%0d] got=%0d exp=%0d", i, level, i); end
    end
    @(negedge clk); idle(); #1;
    n_vec++; if (level !== 5'd3)     begin n_err++; $display("FAIL p0s_level_end got=%0d exp=3", level); end
    n_vec++; if (fifo_write !== 1'b0) begin n_err++; $display("FAIL p0s_idle_write got=%b exp=0", fifo_write); end
  endtask

  task automatic test_round_robin();
    logic exp_p0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle(); p0_req = 1'b1; p1_req = 1'b1; p0_data = 1'b0; p1_data = 1'b1; #1;
      exp_p0 = (i % 2 == 0);
      n_vec++; if (p0_gnt !== exp_p0)        begin n_err++; $display("FAIL rr_p0[%0d] got=%b exp=%b", i, p0_gnt, exp_p0); end
      n_vec++; if (p1_gnt !== !exp_p0)       begin n_err++; $display("FAIL rr_p1[%0d] got=%b exp=%b", i, p1_gnt, !exp_p0); end
      n_vec++; if (fifo_in_data !== !exp_p0) begin n_err++; $display("FAIL rr_data[%0d] got=%b exp=%b", i, fifo_in_data, !exp_p0); end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); p0_req = 1'b1; p0_data = 1'b1; #1;
      n_vec++; if (p0_gnt !== 1'b1) begin n_err++; $display("FAIL rr_solo_p0[%0d] got=%b exp=1", i, p0_gnt); end
      n_vec++; if (p1_gnt !== 1'b0) begin n_err++; $display("FAIL rr_solo_p1[%0d] got=%b exp=0", i, p1_gnt); end
    end
    @(negedge clk); idle(); #1;
    n_vec++; if (level !== 5'd7) begin n_err++; $display("FAIL rr_level got=%0d exp=7", level); end
  endtask

  task automatic test_full();
    do_reset();
    fill_p0(16);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle(); p0_req = 1'b1; p1_req = 1'b1; #1;
      n_vec++; if (level !== 5'd16)     begin n_err++; $display("FAIL full_level[%0d] got=%0d exp=16", i, level); end
      n_vec++; if (p0_gnt !== 1'b0)     begin n_err++; $display("FAIL full_p0[%0d] got=%b exp=0", i, p0_gnt); end
      n_vec++; if (p1_gnt !== 1'b0)     begin n_err++; $display("FAIL full_p1[%0d] got=%b exp=0", i, p1_gnt); end
      n_vec++; if (fifo_write !== 1'b0) begin n_err++; $display("FAIL full_write[%0d] got=%b exp=0", i, fifo_write); end
    end
    // At DEPTH a read goes ahead, but the simultaneous write is refused.
    @(negedge clk); idle(); p0_req = 1'b1; c_req = 1'b1; #1;
    n_vec++; if (fifo_read !== 1'b1)  begin n_err++; $display("FAIL full_rd got=%b exp=1", fifo_read); end
    n_vec++; if (fifo_write !== 1'b0) begin n_err++; $display("FAIL full_rdwr got=%b exp=0", fifo_write); end
    @(negedge clk); idle(); #1;
    n_vec++; if (level !== 5'd15)  begin n_err++; $display("FAIL full_drain_level got=%0d exp=15", level); end
    n_vec++; if (c_valid !== 1'b1) begin n_err++; $display("FAIL full_c_valid got=%b exp=1", c_valid); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    fill_p0(8);
    @(negedge clk); idle(); p1_req = 1'b1; p1_data = 1'b1; c_req = 1'b1; #1;
    n_vec++; if (fifo_read !== 1'b1)  begin n_err++; $display("FAIL sim_read got=%b exp=1", fifo_read); end
    n_vec++; if (fifo_write !== 1'b1) begin n_err++; $display("FAIL sim_write got=%b exp=1", fifo_write); end
    n_vec++; if (p1_gnt !== 1'b1)     begin n_err++; $display("FAIL sim_p1gnt got=%b exp=1", p1_gnt); end
    n_vec++; if (level !== 5'd8)      begin n_err++; $display("FAIL sim_level_pre got=%0d exp=8", level); end
    @(negedge clk); idle(); fifo_out_data = 1'b1; #1;
    n_vec++; if (c_valid !== 1'b1) begin n_err++; $display("FAIL sim_c_valid got=%b exp=1", c_valid); end
    n_vec++; if (c_data !== 1'b1)  begin n_err++; $display("FAIL sim_c_data got=%b exp=1", c_data); end
    n_vec++; if (level !== 5'd8)   begin n_err++; $display("FAIL sim_level got=%0d exp=8", level); end
    @(negedge clk); idle(); #1;
    n_vec++; if (c_valid !== 1'b0) begin n_err++; $display("FAIL sim_c_valid_off got=%b exp=0", c_valid); end
    n_vec++; if (c_data !== 1'b0)  begin n_err++; $display("FAIL sim_c_data_off got=%b exp=0", c_data); end
    fifo_out_data = 1'b0;
  endtask

  task automatic test_empty_read();
    do_reset();
    @(negedge clk); idle(); c_req = 1'b1; #1;
    n_vec++; if (fifo_read !== 1'b0) begin n_err++; $display("FAIL emp_read got=%b exp=0", fifo_read); end
    @(negedge clk); idle(); c_req = 1'b1; #1;
    n_vec++; if (c_valid !== 1'b0) begin n_err++; $display("FAIL emp_c_valid got=%b exp=0", c_valid); end
    n_vec++; if (level !== 5'd0)   begin n_err++; $display("FAIL emp_level got=%0d exp=0", level); end
    n_vec++; if (err !== 1'b0)     begin n_err++; $display("FAIL emp_err got=%b exp=0", err); end
    // At level 0 only the write of a read+write pair goes ahead.
    @(negedge clk); idle(); c_req = 1'b1; p0_req = 1'b1; #1;
    n_vec++; if (fifo_write !== 1'b1) begin n_err++; $display("FAIL emp_rw_write got=%b exp=1", fifo_write); end
    n_vec++; if (fifo_read !== 1'b0)  begin n_err++; $display("FAIL emp_rw_read got=%b exp=0", fifo_read); end
    @(negedge clk); idle(); #1;
    n_vec++; if (level !== 5'd1)   begin n_err++; $display("FAIL emp_rw_level got=%0d exp=1", level); end
    n_vec++; if (c_valid !== 1'b0) begin n_err++; $display("FAIL emp_rw_c_valid got=%b exp=0", c_valid); end
  endtask

  task automatic test_halt();
    // Level is 1 here. The write during the overflow cycle still happens.
    @(negedge clk); idle(); p0_req = 1'b1; fifo_overflow = 1'b1; #1;
    n_vec++; if (p0_gnt !== 1'b1) begin n_err++; $display("FAIL halt_pre_gnt got=%b exp=1", p0_gnt); end
    n_vec++; if (err !== 1'b0)    begin n_err++; $display("FAIL halt_pre_err got=%b exp=0", err); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle(); p0_req = 1'b1; p1_req = 1'b1; c_req = 1'b1; #1;
      n_vec++; if (err !== 1'b1)        begin n_err++; $display("FAIL halt_err[%0d] got=%b exp=1", i, err); end
      n_vec++; if (p0_gnt !== 1'b0)     begin n_err++; $display("FAIL halt_p0[%0d] got=%b exp=0", i, p0_gnt); end
      n_vec++; if (p1_gnt !== 1'b0)     begin n_err++; $display("FAIL halt_p1[%0d] got=%b exp=0", i, p1_gnt); end
      n_vec++; if (fifo_write !== 1'b0) begin n_err++; $display("FAIL halt_write[%0d] got=%b exp=0", i, fifo_write); end
      n_vec++; if (fifo_read !== 1'b0)  begin n_err++; $display("FAIL halt_read[%0d] got=%b exp=0", i, fifo_read); end
      n_vec++; if (level !== 5'd2)      begin n_err++; $display("FAIL halt_level[%0d] got=%0d exp=2", i, level); end
    end
    @(negedge clk); rst = 1'b1; idle(); p0_req = 1'b1; #1;
    n_vec++; if (err !== 1'b0)        begin n_err++; $display("FAIL halt_rst_err got=%b exp=0", err); end
    n_vec++; if (fifo_write !== 1'b0) begin n_err++; $display("FAIL halt_rst_write got=%b exp=0", fifo_write); end
    @(negedge clk); rst = 1'b0; idle(); p0_req = 1'b1; #1;
    n_vec++; if (err !== 1'b0)    begin n_err++; $display("FAIL halt_run_err got=%b exp=0", err); end
    n_vec++; if (level !== 5'd0)  begin n_err++; $display("FAIL halt_run_level got=%0d exp=0", level); end
    n_vec++; if (p0_gnt !== 1'b1) begin n_err++; $display("FAIL halt_run_gnt got=%b exp=1", p0_gnt); end
    // Underflow also halts.
    @(negedge clk); idle(); fifo_underflow = 1'b1;
    @(negedge clk); idle(); p1_req = 1'b1; #1;
    n_vec++; if (err !== 1'b1)    begin n_err++; $display("FAIL uflow_err got=%b exp=1", err); end
    n_vec++; if (p1_gnt !== 1'b0) begin n_err++; $display("FAIL uflow_gnt got=%b exp=0", p1_gnt); end
  endtask

  initial begin
    rst = 1'b1;
    fifo_out_data = 1'b0;
    idle();
    test_reset();
    test_p0_stream();
    test_round_robin();
    test_full();
    test_simultaneous();
    test_empty_read();
    test_halt();
    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim_time got=expired exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
